pipelined_barrel_shifter: RTL and testbench

//  Parametrised, pipelined barrel shifter. Supports logical left, logical right,

---
 rtl/pipelined_barrel_shifter.sv | 142 ++++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready on both sides.
// The shift levels are split evenly across PIPE_STAGES register stages; bubbles collapse.
module pipelined_barrel_shifter #(
  parameter  int WIDTH       = 32,
  parameter  int PIPE_STAGES = 2,
  localparam int AMT_W       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int LPS = (AMT_W + PIPE_STAGES - 1) / PIPE_STAGES;

  logic [PIPE_STAGES-1:0]            stage_valid;
  logic [PIPE_STAGES-1:0][WIDTH-1:0] stage_data;
  logic [PIPE_STAGES-1:0][AMT_W-1:0] stage_amt;
  logic [PIPE_STAGES-1:0][1:0]       stage_op;
  logic [PIPE_STAGES-1:0]            stage_sign;
  logic [PIPE_STAGES:0]              load;

  // One mux level: shift by 2^k according to op.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input logic [1:0] op,
                                                   input logic sign,
                                                   input int k);
    logic [WIDTH-1:0] fill;
    int sh;
    sh   = 1 << k;
    fill = ~({WIDTH{1'b1}} >> sh);
    case (op)
      2'b00:   shift_level = d << sh;
      2'b01:   shift_level = d >> sh;
      2'b10:   shift_level = (d >> sh) | (sign ? fill : '0);
      default: shift_level = (d >> sh) | (d << (WIDTH - sh));
    endcase
  endfunction

  // Backward load chain: a stage may load if it is empty or its contents move on.
  always_comb begin
    load = '0;
    load[PIPE_STAGES] = out_ready;
    for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
      load[s] = !stage_valid[s] || load[s+1];
    end
  end

  for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
    localparam int LO = (gi * LPS < AMT_W) ? gi * LPS : AMT_W;
    localparam int HI = ((gi + 1) * LPS < AMT_W) ? (gi + 1) * LPS : AMT_W;

    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic [AMT_W-1:0] src_amt;
    logic [1:0]       src_op;
    logic             src_sign;
    logic [WIDTH-1:0] shifted;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic [1:0]       op_q, op_d;
    logic             sign_q, sign_d;

    if (gi == 0) begin : g_src_in
      assign src_valid = in_valid;
      assign src_data  = in_data;
      assign src_amt   = in_amt;
      assign src_op    = in_op;
      assign src_sign  = in_data[WIDTH-1];
    end else begin : g_src_stage
      assign src_valid = stage_valid[gi-1];
      assign src_data  = stage_data[gi-1];
      assign src_amt   = stage_amt[gi-1];
      assign src_op    = stage_op[gi-1];
      assign src_sign  = stage_sign[gi-1];
    end

    always_comb begin
      shifted = src_data;
      for (int k = LO; k < HI; k++) begin
        if (src_amt[k]) shifted = shift_level(shifted, src_op, src_sign, k);
      end
    end

    // Payload only moves with a valid item, so a stalled or drained output keeps its data.
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      amt_d   = amt_q;
      op_d    = op_q;
      sign_d  = sign_q;
      if (load[gi]) begin
        valid_d = src_valid;
        if (src_valid) begin
          data_d = shifted;
          amt_d  = src_amt;
          op_d   = src_op;
          sign_d = src_sign;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        amt_q   <= '0;
        op_q    <= '0;
        sign_q  <= 1'b0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
        amt_q   <= amt_d;
        op_q    <= op_d;
        sign_q  <= sign_d;
      end
    end

    assign stage_valid[gi] = valid_q;
    assign stage_data[gi]  = data_q;
    assign stage_amt[gi]   = amt_q;
    assign stage_op[gi]    = op_q;
    assign stage_sign[gi]  = sign_q;
  end

  assign in_ready  = load[0];
  assign out_valid = stage_valid[PIPE_STAGES-1];
  assign out_data  = stage_data[PIPE_STAGES-1];

  // Last-stage control and consumed amount bits have no further reader.
  logic unused_ok;
  assign unused_ok = ^{stage_amt, stage_op[PIPE_STAGES-1], stage_sign[PIPE_STAGES-1]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench: directed cases on a 2-stage instance plus randomized
// streams on 2/1/3/5-stage instances against a behavioural shift model.
module tb_pipelined_barrel_shifter;

  localparam int NRND = 2500;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp_v);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] a,
                                        input logic [1:0] op);
    logic [63:0] dd;
    dd = {d, d} >> a;
    case (op)
      2'b00:   model = d << a;
      2'b01:   model = d >> a;
      2'b10:   model = 32'($signed(d) >>> a);
      default: model = dd[31:0];
    endcase
  endfunction

  // ---------------- directed instance ----------------
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_amt;
  logic [1:0]  in_op;

  pipelined_barrel_shifter #(.WIDTH(32), .PIPE_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // One item through an idle pipe with out_ready high; expects the result
  // PIPE_STAGES cycles after the cycle in which it was presented.
  task automatic run_one(input string tag, input logic [31:0] d, input logic [4:0] a,
                         input logic [1:0] op, input logic [31:0] exp_v);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_amt = a; in_op = op;
    #1 check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      if (lat == 0) in_valid = 1'b0;
      lat++;
      #1;
      if (out_valid) break;
    end
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check(tag, out_data, exp_v);
    $display("[%0t] %s op=%0d amt=%0d in=0x%08h out=0x%08h lat=%0d", $time, tag, op, a, d, out_data, lat);
  endtask

  // ---------------- random instances ----------------
  logic [3:0] rnd_done = '0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_rnd
    localparam int P = (gi == 0) ? 2 : (gi == 1) ? 1 : (gi == 2) ? 3 : 5;
    logic        r_rst, r_in_valid, r_in_ready, r_out_valid, r_out_ready;
    logic [31:0] r_in_data, r_out_data;
    logic [4:0]  r_in_amt;
    logic [1:0]  r_in_op;

    pipelined_barrel_shifter #(.WIDTH(32), .PIPE_STAGES(P)) u_dut (
      .clk(clk), .rst(r_rst),
      .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
      .in_amt(r_in_amt), .in_op(r_in_op),
      .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data)
    );

    initial begin
      logic [31:0] q[$];
      logic [31:0] exp_v;
      int n_in, n_out, cyc;
      r_rst = 1'b1; r_in_valid = 1'b0; r_out_ready = 1'b0;
      r_in_data = '0; r_in_amt = '0; r_in_op = '0;
      repeat (3) @(negedge clk);
      r_rst = 1'b0;
      n_in = 0; n_out = 0; cyc = 0;
      while (n_out < NRND && cyc < 20 * NRND) begin
        @(negedge clk);
        cyc++;
        r_in_valid  = (n_in < NRND) && ($urandom_range(0, 3) != 0);
        r_in_data   = $urandom;
        r_in_amt    = 5'($urandom_range(0, 31));
        r_in_op     = 2'($urandom_range(0, 3));
        r_out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (r_out_valid && r_out_ready) begin
          if (q.size() == 0) begin
            check($sformatf("rnd_p%0d_spurious", P), 32'd1, 32'd0);
          end else begin
            exp_v = q.pop_front();
            check($sformatf("rnd_p%0d_item%0d", P, n_out), r_out_data, exp_v);
            $display("[%0t] rnd p%0d item %0d out=0x%08h", $time, P, n_out, r_out_data);
            n_out++;
          end
        end
        if (r_in_valid && r_in_ready) begin
          q.push_back(model(r_in_data, r_in_amt, r_in_op));
          n_in++;
        end
      end
      check($sformatf("rnd_p%0d_count", P), 32'(n_out), 32'(NRND));
      rnd_done[gi] = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  logic [31:0] t_d[13]   = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h7000_0000,
                             32'h0000_000F, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'hA5A5_5A5A,
                             32'hA5A5_5A5A, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001,
                             32'h8000_0001};
  logic [4:0]  t_a[13]   = '{5'd31, 5'd31, 5'd4, 5'd4, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0,
                             5'd31, 5'd31, 5'd31, 5'd31};
  logic [1:0]  t_op[13]  = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
                             2'd2, 2'd2, 2'd3, 2'd0};
  logic [31:0] t_exp[13] = '{32'h8000_0000, 32'h0000_0001, 32'hF800_0000, 32'h0700_0000,
                             32'hF000_0000, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'hA5A5_5A5A,
                             32'hA5A5_5A5A, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0002,
                             32'h8000_0000};

  initial begin
    logic [31:0] got[$];
    logic [31:0] bp_exp[3];
    logic in_acc;
    int seen;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 13; i++) begin
      run_one($sformatf("dir%0d", i), t_d[i], t_a[i], t_op[i], t_exp[i]);
    end

    // Backpressure: three items, out_ready low.
    bp_exp = '{32'h0000_0006, 32'hC000_0000, 32'h7812_3456};
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_0003; in_amt = 5'd1; in_op = 2'd0;
    #1 check("bp_rdy0", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_data = 32'h8000_0000; in_amt = 5'd1; in_op = 2'd2;
    #1 check("bp_rdy1", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_data = 32'h1234_5678; in_amt = 5'd8; in_op = 2'd3;
    #1;
    check("bp_full", 32'(in_ready), 32'd0);
    check("bp_valid", 32'(out_valid), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("bp_stable", out_data, bp_exp[0]);
      check("bp_stall_rdy", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_acc = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) got.push_back(out_data);
      if (in_valid && in_ready) in_acc = 1'b1;
      @(negedge clk);
      if (in_acc) in_valid = 1'b0;
    end
    check("bp_count", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_item%0d", i), (i < got.size()) ? got[i] : 32'hDEAD_BEEF, bp_exp[i]);
      $display("[%0t] bp item %0d out=0x%08h", $time, i, (i < got.size()) ? got[i] : 32'h0);
    end

    // Reset with two items in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_0001; in_amt = 5'd0; in_op = 2'd0;
    @(negedge clk);
    in_data = 32'hFFFF_0000; in_amt = 5'd16; in_op = 2'd1;
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("no_stale", 32'(seen), 32'd0);
    $display("[%0t] reset flush: stale outputs seen=%0d", $time, seen);
    run_one("post_rst", 32'h0000_00F0, 5'd4, 2'd1, 32'h0000_000F);

    for (int c = 0; c < 60000 && !(&rnd_done); c++) @(negedge clk);
    check("rnd_done", 32'(rnd_done), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
